muldiv_ctrl: RTL and testbench

//  Multi-cycle multiply/divide sequencer beside the EXE stage ALU. Takes forwarded SrcAE/SrcBE
//  for MULT/MULTU/DIV/DIVU, runs a 32-step iterative shift-add/restoring-divide loop and stalls
//  the pipeline until done. Owns the HI/LO registers, also written by MTHI/MTLO.

---
 rtl/muldiv_pkg.sv | 36 +++
 rtl/muldiv_step.sv | 52 +++++
 rtl/muldiv_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// ---------------------------------------------------------------------------
// muldiv_pkg
// Shared definitions for the multiply/divide sequencer beside the EXE ALU:
// operation encodings carried on MdOpE, controller state encodings and the
// default operand width.
// Build option: MD_FAST_MUL_EN (see muldiv_ctrl) does not change anything here.
// ---------------------------------------------------------------------------
package muldiv_pkg;

    localparam int MD_WIDTH = 32;
    localparam int MD_CNT_W = 5;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } mdOp_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIX  = 2'b10,
        ST_DONE = 2'b11
    } mdState_e;

    // MULT and DIV treat operands as two's complement; the U variants do not.
    function automatic logic opIsSigned(input mdOp_e op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

    function automatic logic opIsDiv(input mdOp_e op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// ---------------------------------------------------------------------------
// muldiv_step
// Combinational single iteration of the multiply/divide loop.
// The accumulator is 2*WIDTH+1 bits: bits [2*WIDTH:WIDTH] are the upper half
// (partial product or partial remainder), bits [WIDTH-1:0] the lower half
// (remaining multiplier bits or quotient bits being built).
// Ports:
//   isDiv     in   1            1 = restoring-divide step, 0 = shift-add step
//   accIn     in   2*WIDTH+1    accumulator before the step
//   operandB  in   WIDTH        multiplicand (mul) or divisor (div) magnitude
//   accOut    out  2*WIDTH+1    accumulator after the step
// ---------------------------------------------------------------------------
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic               isDiv,
    input  logic [2*WIDTH:0]   accIn,
    input  logic [WIDTH-1:0]   operandB,
    output logic [2*WIDTH:0]   accOut
);

    logic [WIDTH:0]   mulUpper;
    logic [WIDTH:0]   divShifted;
    logic [WIDTH+1:0] divDiff;

    // Multiply: add the multiplicand when the current multiplier bit is set,
    // then shift the whole accumulator right. The upper half has a spare top
    // bit so the carry out of the add always survives the shift.
    // Divide: shift the remainder/quotient pair left, trial-subtract the
    // divisor, keep the difference and set the quotient bit if no borrow.
    always_comb begin
        mulUpper = accIn[2*WIDTH:WIDTH];
        if (accIn[0]) begin
            mulUpper = accIn[2*WIDTH:WIDTH] + {1'b0, operandB};
        end

        divShifted = {accIn[2*WIDTH-1:WIDTH], accIn[WIDTH-1]};
        divDiff    = {1'b0, divShifted} - {2'b00, operandB};

        accOut = {1'b0, mulUpper, accIn[WIDTH-1:1]};
        if (isDiv) begin
            if (!divDiff[WIDTH+1]) begin
                accOut = {divDiff[WIDTH:0], accIn[WIDTH-2:0], 1'b1};
            end else begin
                accOut = {divShifted, accIn[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// ---------------------------------------------------------------------------
// muldiv_ctrl
// Multi-cycle multiply/divide sequencer beside the EXE stage ALU. Runs
// MULT/MULTU/DIV/DIVU over a 32-step iterative loop, stalls the pipeline
// until the result is ready and owns the HI/LO registers (also written by
// MTHI/MTLO).
// Build option: define MD_FAST_MUL_EN to compute MULT/MULTU in one FIX cycle
// with '*' (2-cycle stall); without it every operation is iterative and no
// multiplier is synthesized.
// Ports:
//   clk       in   1      clock, rising edge
//   rst       in   1      synchronous active-high reset
//   StartE    in   1      mul/div valid in EXE, held high while StallMD
//   MdOpE     in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   SrcAE     in   WIDTH  operand A (multiplicand / dividend), MTHI/MTLO data
//   SrcBE     in   WIDTH  operand B (multiplier / divisor)
//   HiWriteE  in   1      MTHI
//   LoWriteE  in   1      MTLO
//   FlushE    in   1      aborts any operation in flight
//   StallMD   out  1      hold IF/ID/EXE
//   BusyMD    out  1      sequencer not idle
//   HI        out  WIDTH  remainder / product upper half
//   LO        out  WIDTH  quotient / product lower half
// ---------------------------------------------------------------------------
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH,
    parameter int CNT_W = MD_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             StartE,
    input  logic [1:0]       MdOpE,
    input  logic [WIDTH-1:0] SrcAE,
    input  logic [WIDTH-1:0] SrcBE,
    input  logic             HiWriteE,
    input  logic             LoWriteE,
    input  logic             FlushE,
    output logic             StallMD,
    output logic             BusyMD,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    mdState_e state, nextState;

    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH:0]   acc;
    logic [2*WIDTH:0]   accStep;
    logic [WIDTH-1:0]   opB;
    logic               signA, signB, isDiv, divZero;

    mdOp_e              opE;
    logic               opSigned, opDiv, startAccept, loadDivZero, fastMulSel;
    logic [WIDTH-1:0]   absA, absB, loadA;
    logic [2*WIDTH-1:0] product, fixProduct;
    logic [WIDTH-1:0]   quotient, remainder, fixHi, fixLo;

    assign opE         = mdOp_e'(MdOpE);
    assign opSigned    = opIsSigned(opE);
    assign opDiv       = opIsDiv(opE);
    assign startAccept = (state == ST_IDLE) && StartE && !FlushE;
    assign loadDivZero = opDiv && (SrcBE == '0);

    assign StallMD = StartE && (state != ST_DONE);
    assign BusyMD  = (state != ST_IDLE);

    muldiv_step #(.WIDTH(WIDTH)) uStep (
        .isDiv    (isDiv),
        .accIn    (acc),
        .operandB (opB),
        .accOut   (accStep)
    );

`ifdef MD_FAST_MUL_EN
    // Multiplies bypass the loop entirely; the magnitudes loaded in IDLE are
    // multiplied directly during FIX.
    assign fastMulSel = !opDiv;
    assign product    = {{WIDTH{1'b0}}, acc[WIDTH-1:0]} * {{WIDTH{1'b0}}, opB};
`else
    assign fastMulSel = 1'b0;
    assign product    = acc[2*WIDTH-1:0];
`endif

    assign quotient  = acc[WIDTH-1:0];
    assign remainder = acc[2*WIDTH-1:WIDTH];

    // Operand conditioning for the load in IDLE: signed ops work on
    // magnitudes, and a zero divisor keeps the raw dividend so it can be
    // returned in HI untouched.
    always_comb begin
        absA  = (opSigned && SrcAE[WIDTH-1]) ? -SrcAE : SrcAE;
        absB  = (opSigned && SrcBE[WIDTH-1]) ? -SrcBE : SrcBE;
        loadA = loadDivZero ? SrcAE : absA;
    end

    // Sign fix-up applied in FIX. The quotient takes the XOR of the operand
    // signs and the remainder follows the dividend. -2^31 / -1 needs no
    // special case: the magnitude quotient is 2^31 and is left unnegated.
    always_comb begin
        fixProduct = (signA ^ signB) ? -product : product;
        fixHi      = fixProduct[2*WIDTH-1:WIDTH];
        fixLo      = fixProduct[WIDTH-1:0];
        if (divZero) begin
            fixHi = acc[WIDTH-1:0];
            fixLo = '1;
        end else if (isDiv) begin
            fixHi = signA ? -remainder : remainder;
            fixLo = (signA ^ signB) ? -quotient : quotient;
        end
    end

    // Next-state logic. A flush in any state wins over everything else,
    // including a StartE presented in the same cycle.
    always_comb begin
        nextState = state;
        case (state)
            ST_IDLE: begin
                if (StartE) begin
                    nextState = (loadDivZero || fastMulSel) ? ST_FIX : ST_RUN;
                end
            end
            ST_RUN: begin
                if (cnt == '0) begin
                    nextState = ST_FIX;
                end
            end
            ST_FIX:  nextState = ST_DONE;
            ST_DONE: nextState = ST_IDLE;
            default: nextState = ST_IDLE;
        endcase
        if (FlushE) begin
            nextState = ST_IDLE;
        end
    end

    // State, datapath and HI/LO registers. HI/LO change only on a completed
    // FIX or an MTHI/MTLO in a quiet IDLE cycle, so aborts leave them intact.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            acc     <= '0;
            opB     <= '0;
            signA   <= 1'b0;
            signB   <= 1'b0;
            isDiv   <= 1'b0;
            divZero <= 1'b0;
            HI      <= '0;
            LO      <= '0;
        end else begin
            state <= nextState;
            case (state)
                ST_IDLE: begin
                    if (startAccept) begin
                        acc     <= {{(WIDTH+1){1'b0}}, loadA};
                        opB     <= absB;
                        signA   <= opSigned && SrcAE[WIDTH-1];
                        signB   <= opSigned && SrcBE[WIDTH-1];
                        isDiv   <= opDiv;
                        divZero <= loadDivZero;
                        // All ones equals WIDTH-1 because 2**CNT_W == WIDTH.
                        cnt     <= '1;
                    end else if (!StartE) begin
                        if (HiWriteE) begin
                            HI <= SrcAE;
                        end
                        if (LoWriteE) begin
                            LO <= SrcAE;
                        end
                    end
                end
                ST_RUN: begin
                    acc <= accStep;
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_FIX: begin
                    if (!FlushE) begin
                        HI <= fixHi;
                        LO <= fixLo;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// ---------------------------------------------------------------------------
// tb_muldiv_ctrl
// Directed bench for muldiv_ctrl: hand-computed products, quotients and
// remainders, stall lengths, divide by zero, signed overflow, MTHI/MTLO,
// flush and reset in the middle of an operation.
// ---------------------------------------------------------------------------
module tb_muldiv_ctrl;

    logic        clk;
    logic        rst;
    logic        StartE;
    logic [1:0]  MdOpE;
    logic [31:0] SrcAE;
    logic [31:0] SrcBE;
    logic        HiWriteE;
    logic        LoWriteE;
    logic        FlushE;
    logic        StallMD;
    logic        BusyMD;
    logic [31:0] HI;
    logic [31:0] LO;

    int testsRun  = 0;
    int failCount = 0;
    int mulStall;
    int stalls;

    muldiv_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .StartE   (StartE),
        .MdOpE    (MdOpE),
        .SrcAE    (SrcAE),
        .SrcBE    (SrcBE),
        .HiWriteE (HiWriteE),
        .LoWriteE (LoWriteE),
        .FlushE   (FlushE),
        .StallMD  (StallMD),
        .BusyMD   (BusyMD),
        .HI       (HI),
        .LO       (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Counts cycles with StallMD high, bounded so a stuck DUT still ends.
    task automatic waitDone(output int count);
        count = 0;
        #1;
        while (StallMD === 1'b1 && count < 200) begin
            count++;
            nextCycle();
        end
    endtask

    // Issues one mul/div, checks stall length, HI/LO in DONE and the return to IDLE.
    task automatic applyStimulus(input string tag, input logic [1:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input int expStall,
                                 input logic [31:0] expHi, input logic [31:0] expLo);
        int n;
        MdOpE  = op;
        SrcAE  = a;
        SrcBE  = b;
        StartE = 1'b1;
        waitDone(n);
        checkOutput({tag, " stall"}, 64'(n), 64'(expStall));
        checkOutput({tag, " HI"}, {32'b0, HI}, {32'b0, expHi});
        checkOutput({tag, " LO"}, {32'b0, LO}, {32'b0, expLo});
        StartE = 1'b0;
        SrcAE  = '0;
        SrcBE  = '0;
        nextCycle();
        checkOutput({tag, " idle"}, {63'b0, BusyMD}, 64'd0);
    endtask

    initial begin
`ifdef MD_FAST_MUL_EN
        mulStall = 2;
`else
        mulStall = 34;
`endif
        rst      = 1'b1;
        StartE   = 1'b0;
        MdOpE    = 2'b00;
        SrcAE    = '0;
        SrcBE    = '0;
        HiWriteE = 1'b0;
        LoWriteE = 1'b0;
        FlushE   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("reset HI", {32'b0, HI}, 64'd0);
        checkOutput("reset LO", {32'b0, LO}, 64'd0);
        checkOutput("reset BusyMD", {63'b0, BusyMD}, 64'd0);
        checkOutput("reset StallMD", {63'b0, StallMD}, 64'd0);
        nextCycle();

        applyStimulus("MULT -3*5",     2'b00, 32'hFFFFFFFD, 32'd5,        mulStall, 32'hFFFFFFFF, 32'hFFFFFFF1);
        applyStimulus("DIVU 100/7",    2'b11, 32'd100,      32'd7,        34,       32'd2,        32'd14);
        applyStimulus("DIV -7/2",      2'b10, 32'hFFFFFFF9, 32'd2,        34,       32'hFFFFFFFF, 32'hFFFFFFFD);
        applyStimulus("DIV 7/-2",      2'b10, 32'd7,        32'hFFFFFFFE, 34,       32'd1,        32'hFFFFFFFD);
        applyStimulus("DIV 9/0",       2'b10, 32'd9,        32'd0,        2,        32'd9,        32'hFFFFFFFF);
        applyStimulus("MULTU max*max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, mulStall, 32'hFFFFFFFE, 32'd1);
        applyStimulus("DIV ovf",       2'b10, 32'h80000000, 32'hFFFFFFFF, 34,       32'd0,        32'h80000000);
        applyStimulus("MULT -1*-1",    2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, mulStall, 32'd0,        32'd1);

        // MTHI and MTLO together, then MTHI alone
        HiWriteE = 1'b1;
        LoWriteE = 1'b1;
        SrcAE    = 32'h0000ABCD;
        nextCycle();
        LoWriteE = 1'b0;
        SrcAE    = 32'h00001234;
        nextCycle();
        HiWriteE = 1'b0;
        SrcAE    = '0;
        #1;
        checkOutput("MTHI HI", {32'b0, HI}, 64'h1234);
        checkOutput("MTLO LO", {32'b0, LO}, 64'hABCD);

        // Flush at RUN step 10 of a DIV
        MdOpE  = 2'b10;
        SrcAE  = 32'd1000;
        SrcBE  = 32'd3;
        StartE = 1'b1;
        repeat (10) nextCycle();
        checkOutput("flush busy before", {63'b0, BusyMD}, 64'd1);
        FlushE = 1'b1;
        nextCycle();
        FlushE = 1'b0;
        StartE = 1'b0;
        #1;
        checkOutput("flush BusyMD", {63'b0, BusyMD}, 64'd0);
        checkOutput("flush StallMD", {63'b0, StallMD}, 64'd0);
        checkOutput("flush HI", {32'b0, HI}, 64'h1234);
        checkOutput("flush LO", {32'b0, LO}, 64'hABCD);
        nextCycle();

        // Reset during RUN
        MdOpE  = 2'b11;
        SrcAE  = 32'd50;
        SrcBE  = 32'd6;
        StartE = 1'b1;
        repeat (5) nextCycle();
        rst = 1'b1;
        nextCycle();
        rst    = 1'b0;
        StartE = 1'b0;
        #1;
        checkOutput("rst HI", {32'b0, HI}, 64'd0);
        checkOutput("rst LO", {32'b0, LO}, 64'd0);
        checkOutput("rst BusyMD", {63'b0, BusyMD}, 64'd0);
        nextCycle();

        // MTLO alongside StartE is ignored; the multiply still completes
        LoWriteE = 1'b1;
        SrcAE    = 32'h55;
        nextCycle();
        MdOpE  = 2'b01;
        SrcAE  = 32'd7;
        SrcBE  = 32'd6;
        StartE = 1'b1;
        nextCycle();
        LoWriteE = 1'b0;
        checkOutput("MTLO+Start LO", {32'b0, LO}, 64'h55);
        waitDone(stalls);
        checkOutput("MULTU 7*6 HI", {32'b0, HI}, 64'd0);
        checkOutput("MULTU 7*6 LO", {32'b0, LO}, 64'd42);
        StartE = 1'b0;
        nextCycle();

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
